// File: rtl/mem_arbiter.sv
// Shares one memory port between CPU and DMA; req -> done in WAIT_STATES+2 cycles, one transfer per WAIT_STATES+3 cycles.
// Requesters hold req until their done pulse; DMA is forced in after STARVE_LIMIT CPU wins and capped at DMA_MAX_BURST.
module mem_arbiter #(
    parameter int unsigned WAIT_STATES   = 1,
    parameter int unsigned STARVE_LIMIT  = 3,
    parameter int unsigned DMA_MAX_BURST = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_done,
    input  logic        dma_req,
    input  logic        dma_write,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic [7:0]  dma_rdata,
    output logic        dma_done,
    output logic [15:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_LAST  = 3'(WAIT_STATES);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [3:0] BURST_MAX  = 4'(DMA_MAX_BURST);

    state_t      state_q;
    logic [2:0]  wait_q;
    logic [3:0]  starve_q;
    logic [3:0]  burst_q;
    logic        write_q;
    logic        owner_q;
    logic        busy_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [7:0]  cpu_rdata_q;
    logic [7:0]  dma_rdata_q;
    logic        cpu_done_q;
    logic        dma_done_q;

    logic        grant_dma_d;
    logic [3:0]  starve_d;
    logic [3:0]  burst_d;

    // owner_q doubles as "last grant was DMA"; it is 0 after reset, so the first DMA grant starts a fresh burst.
    always_comb begin
        grant_dma_d = dma_req && (!cpu_req || (starve_q == STARVE_MAX) ||
                                  (owner_q && (burst_q < BURST_MAX)));
        starve_d    = starve_q;
        burst_d     = burst_q;
        if (grant_dma_d) begin
            starve_d = 4'd0;
            if (!owner_q) begin
                burst_d = 4'd1;
            end else if (burst_q != 4'hF) begin
                burst_d = burst_q + 4'd1;
            end
        end else begin
            burst_d = 4'd0;
            if (!dma_req) begin
                starve_d = 4'd0;
            end else if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wait_q      <= 3'd0;
            starve_q    <= 4'd0;
            burst_q     <= 4'd0;
            write_q     <= 1'b0;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 8'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            cpu_rdata_q <= 8'd0;
            dma_rdata_q <= 8'd0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req || dma_req) begin
                        owner_q     <= grant_dma_d;
                        starve_q    <= starve_d;
                        burst_q     <= burst_d;
                        wait_q      <= 3'd0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ACCESS;
                        if (grant_dma_d) begin
                            mem_addr_q  <= dma_addr;
                            mem_wdata_q <= dma_wdata;
                            write_q     <= dma_write;
                            mem_read_q  <= !dma_write;
                            mem_write_q <= dma_write;
                        end else begin
                            mem_addr_q  <= cpu_addr;
                            mem_wdata_q <= cpu_wdata;
                            write_q     <= cpu_write;
                            mem_read_q  <= !cpu_write;
                            mem_write_q <= cpu_write;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (wait_q == WAIT_LAST) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        state_q     <= ST_DONE;
                        // Read data is sampled in the last strobe cycle, so it is already stable for the done pulse.
                        if (owner_q) begin
                            dma_done_q <= 1'b1;
                            if (!write_q) begin
                                dma_rdata_q <= mem_rdata;
                            end
                        end else begin
                            cpu_done_q <= 1'b1;
                            if (!write_q) begin
                                cpu_rdata_q <= mem_rdata;
                            end
                        end
                    end else begin
                        wait_q <= wait_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    cpu_done_q <= 1'b0;
                    dma_done_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign dma_done  = dma_done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign owner     = owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with one wait state, one with none.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_cpu_req = 1'b0, a_cpu_write = 1'b0;
    logic [15:0] a_cpu_addr = 16'd0;
    logic [7:0]  a_cpu_wdata = 8'd0;
    logic [7:0]  a_cpu_rdata;
    logic        a_cpu_done;
    logic        a_dma_req = 1'b0, a_dma_write = 1'b0;
    logic [15:0] a_dma_addr = 16'd0;
    logic [7:0]  a_dma_wdata = 8'd0;
    logic [7:0]  a_dma_rdata;
    logic        a_dma_done;
    logic [15:0] a_mem_addr;
    logic        a_mem_read, a_mem_write;
    logic [7:0]  a_mem_wdata, a_mem_rdata;
    logic        a_owner, a_busy;

    logic        b_cpu_req = 1'b0, b_cpu_write = 1'b0;
    logic [15:0] b_cpu_addr = 16'd0;
    logic [7:0]  b_cpu_wdata = 8'd0;
    logic [7:0]  b_cpu_rdata;
    logic        b_cpu_done;
    logic        b_dma_req = 1'b0, b_dma_write = 1'b0;
    logic [15:0] b_dma_addr = 16'd0;
    logic [7:0]  b_dma_wdata = 8'd0;
    logic [7:0]  b_dma_rdata;
    logic        b_dma_done;
    logic [15:0] b_mem_addr;
    logic        b_mem_read, b_mem_write;
    logic [7:0]  b_mem_wdata, b_mem_rdata;
    logic        b_owner, b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        case (a)
            16'h0000: return 8'hFD;
            16'h0001: return 8'hCB;
            16'h0002: return 8'h34;
            16'h0003: return 8'h06;
            default:  return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    assign a_mem_rdata = mem_fn(a_mem_addr);
    assign b_mem_rdata = mem_fn(b_mem_addr);

    mem_arbiter #(.WAIT_STATES(1), .STARVE_LIMIT(3), .DMA_MAX_BURST(2)) u_dut_a (
        .clk(clk), .reset(rst_n),
        .cpu_req(a_cpu_req), .cpu_write(a_cpu_write), .cpu_addr(a_cpu_addr),
        .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_done(a_cpu_done),
        .dma_req(a_dma_req), .dma_write(a_dma_write), .dma_addr(a_dma_addr),
        .dma_wdata(a_dma_wdata), .dma_rdata(a_dma_rdata), .dma_done(a_dma_done),
        .mem_addr(a_mem_addr), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .owner(a_owner), .busy(a_busy)
    );

    mem_arbiter #(.WAIT_STATES(0), .STARVE_LIMIT(3), .DMA_MAX_BURST(2)) u_dut_b (
        .clk(clk), .reset(rst_n),
        .cpu_req(b_cpu_req), .cpu_write(b_cpu_write), .cpu_addr(b_cpu_addr),
        .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done),
        .dma_req(b_dma_req), .dma_write(b_dma_write), .dma_addr(b_dma_addr),
        .dma_wdata(b_dma_wdata), .dma_rdata(b_dma_rdata), .dma_done(b_dma_done),
        .mem_addr(b_mem_addr), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .owner(b_owner), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0]  grant_seq;
        logic [7:0]  rd_exp [4];
        rd_exp[0] = 8'hFD; rd_exp[1] = 8'hCB; rd_exp[2] = 8'h34; rd_exp[3] = 8'h06;
        grant_seq = 10'b11000_11000; // bit k = 1 -> DMA expected for grant k (LSB first)

        // Reset state
        tick(); tick();
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_mem_read", 32'(a_mem_read), 32'd0);
        chk("rst_mem_write", 32'(a_mem_write), 32'd0);
        chk("rst_owner", 32'(a_owner), 32'd0);
        chk("rst_mem_addr", 32'(a_mem_addr), 32'd0);
        chk("rst_cpu_rdata", 32'(a_cpu_rdata), 32'd0);
        chk("rst_done", 32'({a_cpu_done, a_dma_done}), 32'd0);
        rst_n = 1'b1;
        tick();

        // CPU read of 0x0002, one wait state
        a_cpu_req = 1'b1; a_cpu_write = 1'b0; a_cpu_addr = 16'h0002;
        tick();
        chk("rd_c1_read", 32'(a_mem_read), 32'd1);
        chk("rd_c1_addr", 32'(a_mem_addr), 32'h0002);
        chk("rd_c1_busy", 32'(a_busy), 32'd1);
        chk("rd_c1_done", 32'({a_cpu_done, a_dma_done}), 32'd0);
        tick();
        chk("rd_c2_read", 32'(a_mem_read), 32'd1);
        chk("rd_c2_done", 32'({a_cpu_done, a_dma_done}), 32'd0);
        tick();
        chk("rd_c3_read", 32'(a_mem_read), 32'd0);
        chk("rd_c3_cpu_done", 32'(a_cpu_done), 32'd1);
        chk("rd_c3_dma_done", 32'(a_dma_done), 32'd0);
        chk("rd_c3_rdata", 32'(a_cpu_rdata), 32'h34);
        a_cpu_req = 1'b0;
        tick();
        chk("rd_c4_done", 32'({a_cpu_done, a_dma_done}), 32'd0);
        chk("rd_c4_busy", 32'(a_busy), 32'd0);
        chk("rd_c4_rdata_hold", 32'(a_cpu_rdata), 32'h34);

        // DMA write 0x5A to 0x1234
        a_dma_req = 1'b1; a_dma_write = 1'b1; a_dma_addr = 16'h1234; a_dma_wdata = 8'h5A;
        tick();
        chk("dw_c1_strobes", 32'({a_mem_write, a_mem_read}), 32'b10);
        chk("dw_c1_addr", 32'(a_mem_addr), 32'h1234);
        chk("dw_c1_wdata", 32'(a_mem_wdata), 32'h5A);
        chk("dw_c1_owner", 32'(a_owner), 32'd1);
        tick();
        chk("dw_c2_strobes", 32'({a_mem_write, a_mem_read}), 32'b10);
        chk("dw_c2_done", 32'(a_dma_done), 32'd0);
        tick();
        chk("dw_c3_strobes", 32'({a_mem_write, a_mem_read}), 32'b00);
        chk("dw_c3_done", 32'({a_cpu_done, a_dma_done}), 32'b01);
        chk("dw_c3_dma_rdata", 32'(a_dma_rdata), 32'd0);
        a_dma_req = 1'b0; a_dma_write = 1'b0;
        tick();
        chk("dw_c4_busy", 32'(a_busy), 32'd0);

        // Four back-to-back CPU reads
        a_cpu_req = 1'b1; a_cpu_write = 1'b0; a_cpu_addr = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b2b_read", 32'(a_mem_read), 32'd1);
            chk("b2b_addr", 32'(a_mem_addr), 32'(i));
            chk("b2b_owner", 32'(a_owner), 32'd0);
            tick();
            tick();
            chk("b2b_done", 32'(a_cpu_done), 32'd1);
            chk("b2b_rdata", 32'(a_cpu_rdata), 32'(rd_exp[i]));
            if (i == 3) a_cpu_req = 1'b0;
            else a_cpu_addr = 16'(i + 1);
            tick();
            chk("b2b_gap_busy", 32'(a_busy), 32'd0);
            chk("b2b_gap_done", 32'(a_cpu_done), 32'd0);
        end

        // Both requesting continuously: starvation limit and burst cap
        a_cpu_req = 1'b1; a_cpu_addr = 16'h0001;
        a_dma_req = 1'b1; a_dma_write = 1'b0; a_dma_addr = 16'h0100;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("arb_owner", 32'(a_owner), 32'(grant_seq[k]));
            chk("arb_addr", 32'(a_mem_addr), grant_seq[k] ? 32'h0100 : 32'h0001);
            tick();
            tick();
            chk("arb_done", 32'({a_cpu_done, a_dma_done}), grant_seq[k] ? 32'b01 : 32'b10);
            if (grant_seq[k]) chk("arb_dma_rdata", 32'(a_dma_rdata), 32'hA5);
            else chk("arb_cpu_rdata", 32'(a_cpu_rdata), 32'hCB);
            if (k == 9) begin
                a_cpu_req = 1'b0; a_dma_req = 1'b0;
            end
            tick();
            chk("arb_gap_busy", 32'(a_busy), 32'd0);
        end

        // Reset asserted in the second ACCESS cycle of a CPU write
        a_cpu_req = 1'b1; a_cpu_write = 1'b1; a_cpu_addr = 16'h0040; a_cpu_wdata = 8'h77;
        tick();
        chk("ra_c1_write", 32'(a_mem_write), 32'd1);
        tick();
        chk("ra_c2_write", 32'(a_mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ra_async_outs", 32'({a_mem_write, a_busy, a_owner, a_cpu_done}), 32'd0);
        a_cpu_req = 1'b0; a_cpu_write = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("ra_no_done", 32'({a_cpu_done, a_dma_done, a_busy}), 32'd0);
        end
        a_cpu_req = 1'b1; a_cpu_addr = 16'h0003;
        tick();
        chk("ra_new_read", 32'(a_mem_read), 32'd1);
        tick();
        tick();
        chk("ra_new_done", 32'(a_cpu_done), 32'd1);
        chk("ra_new_rdata", 32'(a_cpu_rdata), 32'h06);
        a_cpu_req = 1'b0;
        tick();

        // Zero wait states: CPU read of 0x0003
        b_cpu_req = 1'b1; b_cpu_write = 1'b0; b_cpu_addr = 16'h0003;
        tick();
        chk("w0_c1_read", 32'(b_mem_read), 32'd1);
        chk("w0_c1_done", 32'(b_cpu_done), 32'd0);
        tick();
        chk("w0_c2_read", 32'(b_mem_read), 32'd0);
        chk("w0_c2_done", 32'(b_cpu_done), 32'd1);
        chk("w0_c2_rdata", 32'(b_cpu_rdata), 32'h06);
        b_cpu_req = 1'b0;
        tick();
        chk("w0_c3_done", 32'({b_cpu_done, b_busy}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
